game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game-flow FSM. Drives the 2-bit state bus consumed by the colour mapper:
//  00 title (blue screen), 01 dog intro and 10 play (sprites drawn), 11 game over (black).
//  Counts frames, rounds, hits and misses, and pulses duck_launch to the duck motion logic.
//  Sits between the input/hit-detect logic and the VGA colour path.
// PARAMETERS
//  INTRO_FRAMES  120  frames spent in DOG_INTRO before auto-advance to PLAY
//  ROUND_FRAMES  600  frames a duck stays in PLAY before it counts as escaped
//  NUM_ROUNDS    10   ducks per game; OVER is entered after the last round resolves
//  MAX_MISSES    3    misses that end the game early
// PORTS
//  Clk           in   1   system clock (50 MHz)
//  Reset_n       in   1   asynchronous, active-low reset
//  frame_clk     in   1   VGA vsync-derived frame clock, level, synchronous to Clk
//  start         in   1   start key, level; acted on at its rising edge
//  dog_done      in   1   pulse: dog animation finished (early exit from DOG_INTRO)
//  duck_hit      in   1   pulse: shot landed on the duck
//  duck_escaped  in   1   pulse: duck left the screen
//  state         out  2   game_state_t to color_mapper
//  duck_launch   out  1   1-cycle pulse on the DOG_INTRO->PLAY transition
//  frame_tick    out  1   1-cycle pulse on the rising edge of frame_clk
//  round         out  4   current round, 1..NUM_ROUNDS (0 in TITLE)
//  hits, misses  out  4   per-game counters, saturating at 15
// BEHAVIOUR
//  Reset: state=TITLE(00); round=hits=misses=0; duck_launch=frame_tick=0; frame_cnt=0.
//   Reset takes effect mid-game from any state.
//  Edge detection: frame_tick = frame_clk & ~frame_clk_q, registered, so it is 1 cycle late.
//   start_rise is formed the same way.
//  TITLE: on start_rise -> DOG_INTRO; round<=1, hits<=0, misses<=0, frame_cnt<=0.
//  DOG_INTRO: frame_cnt++ on each frame_tick.
//   dog_done, or frame_cnt==INTRO_FRAMES-1 coinciding with a frame_tick -> PLAY.
//   On that transition: duck_launch=1 for exactly 1 cycle, frame_cnt<=0.
//  PLAY: frame_cnt++ on each frame_tick. Resolve the round with priority hit > escape > timeout.
//   Timeout = frame_cnt==ROUND_FRAMES-1 coinciding with a frame_tick.
//   hit: hits++. escape/timeout: misses++.
//   Then: if misses_next==MAX_MISSES or round==NUM_ROUNDS -> OVER.
//   Otherwise -> DOG_INTRO, round++, frame_cnt<=0.
//   Simultaneous duck_hit and duck_escaped in the same cycle counts as one hit only.
//  OVER: counters hold for score display; start_rise -> TITLE (round<=0).
//   A start level held high across the transition does not re-trigger; a new rising edge is needed.
//  Event pulses arriving outside the state that uses them are ignored
//   (e.g. duck_hit in DOG_INTRO does not increment hits).
//  All outputs are registered; state changes 1 cycle after the qualifying input edge.
// CONFIGURATION
//  GAME_SEQ_PAUSE_EN defined: adds input port pause (level).
//   While pause=1 in DOG_INTRO or PLAY: frame_cnt frozen, dog_done/duck_hit/duck_escaped ignored.
//   state is unchanged and duck_launch is suppressed.
//   Releasing pause resumes from the frozen count. pause has no effect in TITLE and OVER.
//  Undefined: no pause port; the FSM behaves as if pause=0.
// STRUCTURE
//  game_pkg: typedef enum logic [1:0] game_state_t {ST_TITLE=2'b00, ST_INTRO=2'b01,
//   ST_PLAY=2'b10, ST_OVER=2'b11}, plus counter width constants.
//   Shared with color_mapper and the duck/dog controllers.
//  Sub-module rise_pulse: 1-flop registered rising-edge detector.
//   Two instances, one for frame_clk and one for start.
// TESTING  (INTRO_FRAMES=4, ROUND_FRAMES=8, NUM_ROUNDS=3, MAX_MISSES=2)
//  1. Reset_n low mid-PLAY -> state=00, round/hits/misses=0 asynchronously.
//  2. start rise, then 4 frame_ticks -> state 00->01->10, one duck_launch pulse, round=1.
//  3. In PLAY, duck_hit and duck_escaped in the same cycle -> hits=1, misses=0, state=01, round=2.
//  4. Two PLAY timeouts of 8 ticks each -> misses=2, state=11, counters hold.
//   Held start causes no restart; a new rise -> state=00.
//  5. Three hits -> state=11 after round 3, hits=3.
//   duck_hit pulsed during DOG_INTRO does not increment hits.
//  6. (GAME_SEQ_PAUSE_EN) pause=1 for 10 ticks in PLAY -> frame_cnt frozen, no timeout.
//   Release -> timeout after the remaining ticks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow types and widths for the sequencer, colour mapper and the
// duck/dog controllers.
package game_pkg;

  // Encoding is consumed directly by the colour mapper.
  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_INTRO = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } game_state_t;

  localparam int ROUND_W = 4;  // round number 0..15
  localparam int CNT_W   = 4;  // hit/miss counters, saturating at 15

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/game_sequencer_rise_pulse.sv
// rise_pulse: registered rising-edge detector. The output pulse is one Clk
// cycle wide and appears one cycle after the input is first seen high.
module rise_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic pulse
);

  logic sig_q;
  logic pulse_q;
  logic pulse_d;

  // Edge: high now, low on the previous cycle.
  always_comb begin
    pulse_d = sig_in & ~sig_q;
  end

  // Delay flop for the previous level plus the registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sig_q   <= sig_in;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game-flow FSM (title -> dog intro -> play -> over).
// Counts frames, rounds, hits and misses and launches each duck.
// Optional feature: define GAME_SEQ_PAUSE_EN to add a 'pause' level input that
// freezes DOG_INTRO and PLAY.
//
// Handshake: dog_done, duck_hit and duck_escaped are single-cycle event pulses
// with no backpressure; they are consumed in the cycle they are high, and only
// when the FSM is in the state that uses them. duck_launch and frame_tick are
// single-cycle output pulses the consumers must accept unconditionally.
module game_sequencer
  import game_pkg::*;
#(
  parameter int INTRO_FRAMES = 120,
  parameter int ROUND_FRAMES = 600,
  parameter int NUM_ROUNDS   = 10,
  parameter int MAX_MISSES   = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               start,
  input  logic               dog_done,
  input  logic               duck_hit,
  input  logic               duck_escaped,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic               pause,
`endif
  output game_state_t        state,
  output logic               duck_launch,
  output logic               frame_tick,
  output logic [ROUND_W-1:0] round,
  output logic [CNT_W-1:0]   hits,
  output logic [CNT_W-1:0]   misses
);

  localparam int FRAME_MAX = (INTRO_FRAMES > ROUND_FRAMES) ? INTRO_FRAMES : ROUND_FRAMES;
  localparam int FCW       = $clog2(FRAME_MAX + 1);
  localparam logic [FCW-1:0]     INTRO_LAST = FCW'(INTRO_FRAMES - 1);
  localparam logic [FCW-1:0]     ROUND_LAST = FCW'(ROUND_FRAMES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0]   MISS_LIMIT = CNT_W'(MAX_MISSES);

  game_state_t        state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [CNT_W-1:0]   hits_q, hits_d;
  logic [CNT_W-1:0]   misses_q, misses_d;
  logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
  logic               launch_q, launch_d;
  logic [CNT_W-1:0]   hits_nx, misses_nx;
  logic               start_rise;
  logic               hold_frame;
  logic               timeout;

  rise_pulse u_frame_rise (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .sig_in (frame_clk),
    .pulse  (frame_tick)
  );

  rise_pulse u_start_rise (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .sig_in (start),
    .pulse  (start_rise)
  );

`ifdef GAME_SEQ_PAUSE_EN
  assign hold_frame = pause;
`else
  assign hold_frame = 1'b0;
`endif

  assign timeout = frame_tick && (frame_cnt_q == ROUND_LAST);

  // Next-state and counter logic; events outside their owning state are dropped.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    frame_cnt_d = frame_cnt_q;
    launch_d    = 1'b0;
    hits_nx     = hits_q;
    misses_nx   = misses_q;
    case (state_q)
      ST_TITLE: begin
        if (start_rise) begin
          state_d     = ST_INTRO;
          round_d     = ROUND_W'(1);
          hits_d      = '0;
          misses_d    = '0;
          frame_cnt_d = '0;
        end
      end
      ST_INTRO: begin
        if (!hold_frame) begin
          if (dog_done || (frame_tick && (frame_cnt_q == INTRO_LAST))) begin
            state_d     = ST_PLAY;
            launch_d    = 1'b1;
            frame_cnt_d = '0;
          end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end
      end
      ST_PLAY: begin
        if (!hold_frame) begin
          if (duck_hit || duck_escaped || timeout) begin
            // A hit wins over a simultaneous escape or timeout.
            if (duck_hit) hits_nx = sat_inc(hits_q);
            else          misses_nx = sat_inc(misses_q);
            hits_d      = hits_nx;
            misses_d    = misses_nx;
            frame_cnt_d = '0;
            if ((misses_nx == MISS_LIMIT) || (round_q == LAST_ROUND)) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_INTRO;
              round_d = round_q + ROUND_W'(1);
            end
          end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end
      end
      default: begin
        // ST_OVER: scores hold for display until the player restarts.
        if (start_rise) begin
          state_d = ST_TITLE;
          round_d = '0;
        end
      end
    endcase
  end

  // FSM state, counters and registered launch pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_TITLE;
      round_q     <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      frame_cnt_q <= '0;
      launch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      frame_cnt_q <= frame_cnt_d;
      launch_q    <= launch_d;
    end
  end

  assign state       = state_q;
  assign round       = round_q;
  assign hits        = hits_q;
  assign misses      = misses_q;
  assign duck_launch = launch_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized game sessions against a rule-level model.
// Every state transition the DUT makes is popped from an expected queue and
// compared as {state, round, hits, misses, launches so far}.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int INTRO  = 4;
  localparam int ROUNDF = 8;
  localparam int NR     = 3;
  localparam int MM     = 2;
  localparam int EW     = 2 + 4 + 4 + 4 + 8;

  // ---------------- clock / reset / DUT ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;
  logic start = 1'b0;
  logic dog_done = 1'b0;
  logic duck_hit = 1'b0;
  logic duck_escaped = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
  logic pause = 1'b0;
`endif
  game_state_t state;
  logic        duck_launch;
  logic        frame_tick;
  logic [3:0]  round;
  logic [3:0]  hits;
  logic [3:0]  misses;

  always #10 Clk = ~Clk;

  game_sequencer #(
    .INTRO_FRAMES (INTRO),
    .ROUND_FRAMES (ROUNDF),
    .NUM_ROUNDS   (NR),
    .MAX_MISSES   (MM)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .start        (start),
    .dog_done     (dog_done),
    .duck_hit     (duck_hit),
    .duck_escaped (duck_escaped),
`ifdef GAME_SEQ_PAUSE_EN
    .pause        (pause),
`endif
    .state        (state),
    .duck_launch  (duck_launch),
    .frame_tick   (frame_tick),
    .round        (round),
    .hits         (hits),
    .misses       (misses)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int drv_ticks = 0;
  int mon_ticks = 0;
  int mon_launches = 0;
  logic [1:0] prev_state = 2'b00;

  // Reference model: the game's rules, tracked per event.
  int m_round = 0;
  int m_hits = 0;
  int m_misses = 0;
  int m_launches = 0;

  task automatic push_exp(input logic [1:0] st);
    exp_q.push_back({st, 4'(m_round), 4'(m_hits), 4'(m_misses), 8'(m_launches)});
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected record per observed state change.
  always @(posedge Clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    #1;
    if (!Reset_n) begin
      prev_state   = 2'b00;
      mon_launches = 0;
      mon_ticks    = 0;
    end else begin
      if (duck_launch) mon_launches++;
      if (frame_tick) mon_ticks++;
      if (state != prev_state) begin
        n_tests++;
        a = {state, round, hits, misses, 8'(mon_launches)};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_transition: got st=%0d rnd=%0d h=%0d m=%0d l=%0d expected none",
                   state, round, hits, misses, mon_launches);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL transition: got st=%0d rnd=%0d h=%0d m=%0d l=%0d expected st=%0d rnd=%0d h=%0d m=%0d l=%0d",
                     a[21:20], a[19:16], a[15:12], a[11:8], a[7:0],
                     e[21:20], e[19:16], e[15:12], e[11:8], e[7:0]);
          end
        end
        prev_state = state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    drv_ticks++;
    idle($urandom_range(1, 3));
  endtask

  task automatic pulse_he(input bit h, input bit e);
    @(negedge Clk);
    duck_hit = h;
    duck_escaped = e;
    @(negedge Clk);
    duck_hit = 1'b0;
    duck_escaped = 1'b0;
    idle($urandom_range(1, 2));
  endtask

  task automatic pulse_dog();
    @(negedge Clk) dog_done = 1'b1;
    @(negedge Clk) dog_done = 1'b0;
    idle($urandom_range(1, 2));
  endtask

  task automatic start_rise(input int hold);
    @(negedge Clk) start = 1'b1;
    idle(hold);
    start = 1'b0;
    idle($urandom_range(2, 3));
  endtask

  task automatic do_start();
    m_round = 1;
    m_hits = 0;
    m_misses = 0;
    push_exp(2'b01);
    start_rise($urandom_range(1, 4));
  endtask

  task automatic intro_phase(input bit use_dog, input int pre, input bit noise);
    if (noise) begin
      pulse_he(1'b1, 1'($urandom_range(0, 1)));
      start_rise(1);
    end
    m_launches++;
    if (use_dog) begin
      repeat (pre) tick();
      push_exp(2'b10);
      pulse_dog();
    end else begin
      repeat (INTRO - 1) tick();
      push_exp(2'b10);
      tick();
    end
  endtask

  // kind: 0 hit, 1 hit+escape together, 2 escape, 3 timeout.
  task automatic play_phase(input int kind, input int pre, input bit noise, output bit over);
    if (noise) begin
      pulse_dog();
      start_rise(1);
    end
    if (kind < 3) repeat (pre) tick();
    else          repeat (ROUNDF - 1) tick();
    if (kind <= 1) m_hits = (m_hits < 15) ? m_hits + 1 : 15;
    else           m_misses = (m_misses < 15) ? m_misses + 1 : 15;
    over = (m_misses == MM) || (m_round == NR);
    if (over) begin
      push_exp(2'b11);
    end else begin
      m_round++;
      push_exp(2'b01);
    end
    case (kind)
      0: pulse_he(1'b1, 1'b0);
      1: pulse_he(1'b1, 1'b1);
      2: pulse_he(1'b0, 1'b1);
      default: tick();
    endcase
  endtask

  task automatic over_phase(input bit held, input bit noise);
    if (noise) begin
      pulse_he(1'b1, 1'b0);
      pulse_he(1'b0, 1'b1);
      tick();
    end
    m_round = 0;
    push_exp(2'b00);
    if (held) begin
      @(negedge Clk) start = 1'b1;
      idle(8);
      start = 1'b0;
      idle(2);
    end else begin
      start_rise($urandom_range(1, 3));
    end
  endtask

  task automatic reset_mid(input string tag);
    @(negedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check({tag, "_state"}, state, 0);
    check({tag, "_round"}, round, 0);
    check({tag, "_hits"}, hits, 0);
    check({tag, "_misses"}, misses, 0);
    check({tag, "_launch"}, duck_launch, 0);
    idle(2);
    m_round = 0;
    m_hits = 0;
    m_misses = 0;
    m_launches = 0;
    drv_ticks = 0;
    exp_q.delete();
    Reset_n = 1'b1;
    idle(2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit over;
    idle(3);
    check("rst_state", state, 0);
    check("rst_round", round, 0);
    check("rst_hits", hits, 0);
    check("rst_misses", misses, 0);
    check("rst_launch", duck_launch, 0);
    check("rst_frame_tick", frame_tick, 0);
    Reset_n = 1'b1;
    idle(2);

    // Title -> intro -> play on tick count, then reset mid-play.
    do_start();
    intro_phase(1'b0, 0, 1'b0);
    check("play_round", round, 1);
    reset_mid("midplay_rst");

    // Simultaneous hit/escape, then two timeouts end the game on misses.
    do_start();
    intro_phase(1'b0, 0, 1'b0);
    play_phase(1, 3, 1'b0, over);
    check("hit_esc_hits", hits, 1);
    check("hit_esc_misses", misses, 0);
    intro_phase(1'b1, 1, 1'b0);
    play_phase(3, 0, 1'b0, over);
    intro_phase(1'b0, 0, 1'b0);
    play_phase(3, 0, 1'b0, over);
    check("miss_over_flag", int'(over), 1);
    idle(6);
    check("over_hold_misses", misses, 2);
    check("over_hold_round", round, 3);
    over_phase(1'b1, 1'b1);
    check("title_round", round, 0);

    // Three hits; duck_hit pulsed during the intro must not count.
    do_start();
    for (int r = 0; r < NR; r++) begin
      intro_phase(1'b0, 0, 1'b1);
      play_phase(0, $urandom_range(0, ROUNDF - 2), 1'b0, over);
    end
    check("three_hits", hits, 3);
    over_phase(1'b0, 1'b0);

`ifdef GAME_SEQ_PAUSE_EN
    // Pause freezes the frame count and swallows events in PLAY.
    do_start();
    intro_phase(1'b0, 0, 1'b0);
    repeat (3) tick();
    @(negedge Clk) pause = 1'b1;
    repeat (10) tick();
    pulse_he(1'b1, 1'b1);
    pulse_dog();
    check("pause_state", state, 2);
    @(negedge Clk) pause = 1'b0;
    repeat (ROUNDF - 1 - 3) tick();
    m_misses++;
    m_round++;
    push_exp(2'b01);
    tick();
    check("pause_timeout_misses", misses, 1);
    reset_mid("pause_rst");
`endif

    // Randomized sessions.
    for (int g = 0; g < 10; g++) begin
      do_start();
      over = 1'b0;
      while (!over) begin
        intro_phase(1'($urandom_range(0, 1)), $urandom_range(0, INTRO - 2),
                    1'($urandom_range(0, 1)));
        play_phase($urandom_range(0, 3), $urandom_range(0, ROUNDF - 2),
                   1'($urandom_range(0, 1)), over);
      end
      over_phase(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    idle(5);
    check("exp_q_drained", exp_q.size(), 0);
    check("frame_tick_count", mon_ticks, drv_ticks);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
